apb2axi_rd_collector: RTL and testbench
=======================================

APB2AXI_RD_COLLECTOR -- requirements
Module: apb2axi_rd_collector

Interface
REQ-001 SHALL have parameter TAG_NUM, default 4, the number of read tags.
REQ-002 SHALL have parameter TAG_W, default $clog2(TAG_NUM), the tag width.
REQ-003 SHALL have parameter AXI_ID_W, default 4, the AXI RID width; TAG_W <= AXI_ID_W.
REQ-004 SHALL have parameter AXI_DATA_W, default 64, the R data width.
REQ-005 SHALL have ports:
  pclk  in  1  sole clock; all logic on rising edge
  preset  in  1  synchronous, active-high reset
  rd_issue_vld  in  1  AR issued, open tag
  rd_issue_rdy  out  1  tag may be opened
  rd_issue_tag  in  TAG_W  tag being opened
  rd_issue_len  in  8  AXI ARLEN (beats-1)
  rvalid  in  1  AXI R valid
  rready  out  1  AXI R ready
  rid  in  AXI_ID_W  tag = rid[TAG_W-1:0]
  rdata  in  AXI_DATA_W  beat data
  rresp  in  2  beat response
  rlast  in  1  final beat
  rdf_push_vld  out  1  beat to read-data FIFO
  rdf_push_rdy  in  1  RDF accepts
  rdf_push_tag / _data / _resp / _last  out  TAG_W / AXI_DATA_W / 2 / 1  beat fields
  cq_push_vld  out  1  completion to completion FIFO
  cq_push_rdy  in  1  CQ accepts
  cq_push_tag / _resp / _len_err  out  TAG_W / 2 / 1  completion fields
  stray_err  out  1  one-cycle pulse: beat for closed tag dropped

Function
REQ-006 SHALL keep per tag: open bit, 9-bit beat counter, 8-bit expected len, 2-bit worst resp.
REQ-007 rd_issue_rdy SHALL be combinational !open[rd_issue_tag]; on issue handshake, SHALL set open, zero counter, zero worst resp, store len.
REQ-008 SHALL hold one output stage (beat register plus two pending flags: rdf_pend, cq_pend).
REQ-009 rready SHALL equal !rdf_pend && !cq_pend (registered state only; no combinational path from rdf_push_rdy/cq_push_rdy).
REQ-010 On R handshake to an open tag: SHALL load beat register, set rdf_pend; rdf_push_vld high the next cycle (latency 1).
REQ-011 On R handshake to a closed tag: SHALL drop the beat, pulse stray_err next cycle, leave all state unchanged.
REQ-012 Per accepted beat: counter+1; worst resp = max(worst, rresp) numerically (DECERR>SLVERR>EXOKAY>OKAY).
REQ-013 If rlast accepted: SHALL also set cq_pend, cq_push_resp = updated worst, cq_push_len_err = (counter+1 != len+1), and clear open.
REQ-014 If counter reaches len+1 without rlast: further beats SHALL still pass to RDF; len_err reported at rlast.
REQ-015 rdf_pend SHALL clear on rdf_push_vld&&rdf_push_rdy; cq_pend on cq_push_vld&&cq_push_rdy; independently, in any order.
REQ-016 Output fields SHALL stay stable while the corresponding vld is high and unacknowledged.
REQ-017 Tag reopened by issue in the cycle after rlast accept SHALL be legal; an issue in the same cycle as rlast accept for that tag SHALL be refused (rdy low).
REQ-018 Beats of different tags SHALL be forwarded in arrival order; interleaving permitted.

Reset
REQ-019 While preset high: rready, rdf_push_vld, cq_push_vld, stray_err = 0; rd_issue_rdy = 1 for any tag; all open bits, counters, pending flags cleared.
REQ-020 Reset mid-burst SHALL discard the in-flight beat and all tag state; no completion emitted.

Verification
REQ-021 Issue tag1 len=3; 4 beats OKAY, last on 4th, rdf/cq ready -> 4 RDF pushes, 1 CQ push tag1 resp=00 len_err=0.
REQ-022 Issue tag0 len=1; beats resp 00 then 10 (last) -> cq_push_resp=10, len_err=0.
REQ-023 Issue tag2 len=3; rlast on 2nd beat -> cq_push_len_err=1, open[2] cleared.
REQ-024 Beat rid=3 with tag3 closed -> stray_err single pulse, no RDF/CQ push, rready stays 1.
REQ-025 Hold rdf_push_rdy=0 for 5 cycles on a last beat with cq_push_rdy=1 -> CQ handshakes once, rready low until RDF handshake, data stable.
REQ-026 Assert preset during beat 2 of 4 -> outputs 0 next cycle, rd_issue_rdy=1, no completion.

Source files
------------

// File: rtl/apb2axi_rd_collector.sv
// Read-response collector: tracks open AXI read tags, forwards R beats to the
// read-data FIFO through a single output stage and emits one completion per
// burst carrying the worst response and a length-mismatch flag.
module apb2axi_rd_collector #(
   parameter int TAG_NUM    = 4,
   parameter int TAG_W      = $clog2(TAG_NUM),
   parameter int AXI_ID_W   = 4,
   parameter int AXI_DATA_W = 64
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  rd_issue_vld,
   output logic                  rd_issue_rdy,
   input  logic [TAG_W-1:0]      rd_issue_tag,
   input  logic [7:0]            rd_issue_len,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [AXI_ID_W-1:0]   rid,
   input  logic [AXI_DATA_W-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   output logic                  rdf_push_vld,
   input  logic                  rdf_push_rdy,
   output logic [TAG_W-1:0]      rdf_push_tag,
   output logic [AXI_DATA_W-1:0] rdf_push_data,
   output logic [1:0]            rdf_push_resp,
   output logic                  rdf_push_last,
   output logic                  cq_push_vld,
   input  logic                  cq_push_rdy,
   output logic [TAG_W-1:0]      cq_push_tag,
   output logic [1:0]            cq_push_resp,
   output logic                  cq_push_len_err,
   output logic                  stray_err
);

   // one slot per encodable tag so every tag value indexes a real entry
   localparam int SLOTS = 1 << TAG_W;

   logic       open_q  [SLOTS];
   logic [8:0] cnt_q   [SLOTS];
   logic [7:0] len_q   [SLOTS];
   logic [1:0] worst_q [SLOTS];

   logic rdf_pend;
   logic cq_pend;
   logic stray_q;

   logic [TAG_W-1:0] r_tag;
   logic             r_fire;
   logic             r_hit;
   logic             issue_ok;
   logic             issue_fire;
   logic [8:0]       beat_cnt;
   logic [8:0]       len_plus;
   logic [1:0]       beat_worst;

   assign r_tag      = rid[TAG_W-1:0];
   assign r_fire     = rvalid && rready;
   assign r_hit      = open_q[r_tag];
   assign beat_cnt   = cnt_q[r_tag] + 9'd1;
   assign len_plus   = {1'b0, len_q[r_tag]} + 9'd1;
   assign beat_worst = (rresp > worst_q[r_tag]) ? rresp : worst_q[r_tag];

   // a tag can only be opened while closed; a tag closing this cycle is still open
   assign issue_ok     = !open_q[rd_issue_tag];
   assign issue_fire   = rd_issue_vld && issue_ok;
   assign rd_issue_rdy = preset || issue_ok;

   // accept a new beat only when the whole output stage has drained
   assign rready        = !preset && !rdf_pend && !cq_pend;
   assign rdf_push_vld  = !preset && rdf_pend;
   assign cq_push_vld   = !preset && cq_pend;
   assign stray_err     = !preset && stray_q;

   // per-tag bookkeeping: open on issue, count and fold responses per accepted beat
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int unsigned i = 0; i < SLOTS; i++) begin
            open_q[i]  <= 1'b0;
            cnt_q[i]   <= '0;
            len_q[i]   <= '0;
            worst_q[i] <= '0;
         end
      end else begin
         // issue and beat never target the same slot: one needs it closed, the other open
         if (issue_fire) begin
            open_q[rd_issue_tag]  <= 1'b1;
            cnt_q[rd_issue_tag]   <= '0;
            worst_q[rd_issue_tag] <= '0;
            len_q[rd_issue_tag]   <= rd_issue_len;
         end
         if (r_fire && r_hit) begin
            cnt_q[r_tag]   <= beat_cnt;
            worst_q[r_tag] <= beat_worst;
            if (rlast) begin
               open_q[r_tag] <= 1'b0;
            end
         end
      end
   end

   // output stage: beat register, completion register, pending flags and stray pulse
   always_ff @(posedge pclk) begin
      if (preset) begin
         rdf_pend        <= 1'b0;
         cq_pend         <= 1'b0;
         stray_q         <= 1'b0;
         rdf_push_tag    <= '0;
         rdf_push_data   <= '0;
         rdf_push_resp   <= '0;
         rdf_push_last   <= 1'b0;
         cq_push_tag     <= '0;
         cq_push_resp    <= '0;
         cq_push_len_err <= 1'b0;
      end else begin
         stray_q <= r_fire && !r_hit;
         if (rdf_pend && rdf_push_rdy) begin
            rdf_pend <= 1'b0;
         end
         if (cq_pend && cq_push_rdy) begin
            cq_pend <= 1'b0;
         end
         // loads only happen with both flags clear, so they never race the clears above
         if (r_fire && r_hit) begin
            rdf_pend      <= 1'b1;
            rdf_push_tag  <= r_tag;
            rdf_push_data <= rdata;
            rdf_push_resp <= rresp;
            rdf_push_last <= rlast;
            if (rlast) begin
               cq_pend         <= 1'b1;
               cq_push_tag     <= r_tag;
               cq_push_resp    <= beat_worst;
               cq_push_len_err <= (beat_cnt != len_plus);
            end
         end
      end
   end

endmodule

// File: tb/tb_apb2axi_rd_collector.sv
// Randomized bench for apb2axi_rd_collector with a queue-based reference model.
module tb_apb2axi_rd_collector;

   localparam int TAG_NUM = 4;
   localparam int TAG_W   = 2;
   localparam int ID_W    = 4;
   localparam int DW      = 64;

   logic            pclk = 1'b0;
   logic            preset = 1'b1;
   logic            rd_issue_vld = 1'b0;
   logic            rd_issue_rdy;
   logic [TAG_W-1:0] rd_issue_tag = '0;
   logic [7:0]      rd_issue_len = '0;
   logic            rvalid = 1'b0;
   logic            rready;
   logic [ID_W-1:0] rid = '0;
   logic [DW-1:0]   rdata = '0;
   logic [1:0]      rresp = '0;
   logic            rlast = 1'b0;
   logic            rdf_push_vld;
   logic            rdf_push_rdy = 1'b1;
   logic [TAG_W-1:0] rdf_push_tag;
   logic [DW-1:0]   rdf_push_data;
   logic [1:0]      rdf_push_resp;
   logic            rdf_push_last;
   logic            cq_push_vld;
   logic            cq_push_rdy = 1'b1;
   logic [TAG_W-1:0] cq_push_tag;
   logic [1:0]      cq_push_resp;
   logic            cq_push_len_err;
   logic            stray_err;

   always #5 pclk = ~pclk;

   apb2axi_rd_collector #(
      .TAG_NUM   (TAG_NUM),
      .TAG_W     (TAG_W),
      .AXI_ID_W  (ID_W),
      .AXI_DATA_W(DW)
   ) dut (
      .pclk           (pclk),
      .preset         (preset),
      .rd_issue_vld   (rd_issue_vld),
      .rd_issue_rdy   (rd_issue_rdy),
      .rd_issue_tag   (rd_issue_tag),
      .rd_issue_len   (rd_issue_len),
      .rvalid         (rvalid),
      .rready         (rready),
      .rid            (rid),
      .rdata          (rdata),
      .rresp          (rresp),
      .rlast          (rlast),
      .rdf_push_vld   (rdf_push_vld),
      .rdf_push_rdy   (rdf_push_rdy),
      .rdf_push_tag   (rdf_push_tag),
      .rdf_push_data  (rdf_push_data),
      .rdf_push_resp  (rdf_push_resp),
      .rdf_push_last  (rdf_push_last),
      .cq_push_vld    (cq_push_vld),
      .cq_push_rdy    (cq_push_rdy),
      .cq_push_tag    (cq_push_tag),
      .cq_push_resp   (cq_push_resp),
      .cq_push_len_err(cq_push_len_err),
      .stray_err      (stray_err)
   );

   typedef struct {
      logic [1:0]    tag;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   typedef struct {
      logic [1:0] tag;
      logic [1:0] resp;
      logic       len_err;
   } cmp_t;

   // stimulus for the next cycle
   logic            d_preset = 1'b1;
   logic            d_issue_vld = 1'b0;
   logic [1:0]      d_issue_tag = '0;
   logic [7:0]      d_issue_len = '0;
   logic            d_rvalid = 1'b0;
   logic [ID_W-1:0] d_rid = '0;
   logic [DW-1:0]   d_rdata = '0;
   logic [1:0]      d_rresp = '0;
   logic            d_rlast = 1'b0;
   logic            d_rdf_rdy = 1'b1;
   logic            d_cq_rdy = 1'b1;

   // reference model state
   bit          m_open  [TAG_NUM];
   int unsigned m_cnt   [TAG_NUM];
   int unsigned m_len   [TAG_NUM];
   logic [1:0]  m_worst [TAG_NUM];
   beat_t       rdf_q[$];
   cmp_t        cq_q[$];
   bit          stray_flag;
   bit          r_acc;

   int unsigned n_chk;
   int unsigned n_pass;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_clear();
      for (int i = 0; i < TAG_NUM; i++) begin
         m_open[i]  = 1'b0;
         m_cnt[i]   = 0;
         m_len[i]   = 0;
         m_worst[i] = '0;
      end
      rdf_q.delete();
      cq_q.delete();
      stray_flag = 1'b0;
   endtask

   // one clock: apply stimulus, check outputs, advance the model across the next edge
   task automatic step();
      bit         exp_stray;
      bit         exp_rdy;
      bit         iss;
      logic [1:0] t;
      beat_t      b;
      cmp_t       c;
      @(negedge pclk);
      preset       = d_preset;
      rd_issue_vld = d_issue_vld;
      rd_issue_tag = d_issue_tag;
      rd_issue_len = d_issue_len;
      rvalid       = d_rvalid;
      rid          = d_rid;
      rdata        = d_rdata;
      rresp        = d_rresp;
      rlast        = d_rlast;
      rdf_push_rdy = d_rdf_rdy;
      cq_push_rdy  = d_cq_rdy;
      #1;
      exp_stray  = stray_flag && !d_preset;
      stray_flag = 1'b0;
      r_acc      = 1'b0;
      chk("stray_err", stray_err, exp_stray);
      if (d_preset) begin
         chk("rst_rready", rready, 0);
         chk("rst_rdf_vld", rdf_push_vld, 0);
         chk("rst_cq_vld", cq_push_vld, 0);
         chk("rst_issue_rdy", rd_issue_rdy, 1);
         model_clear();
         return;
      end
      exp_rdy = (rdf_q.size() == 0) && (cq_q.size() == 0);
      chk("rready", rready, exp_rdy);
      chk("rdf_vld", rdf_push_vld, rdf_q.size() != 0);
      chk("cq_vld", cq_push_vld, cq_q.size() != 0);
      chk("issue_rdy", rd_issue_rdy, !m_open[d_issue_tag]);
      if (rdf_q.size() != 0) begin
         chk("rdf_tag", rdf_push_tag, rdf_q[0].tag);
         chk("rdf_data", rdf_push_data, rdf_q[0].data);
         chk("rdf_resp", rdf_push_resp, rdf_q[0].resp);
         chk("rdf_last", rdf_push_last, rdf_q[0].last);
         if (d_rdf_rdy) void'(rdf_q.pop_front());
      end
      if (cq_q.size() != 0) begin
         chk("cq_tag", cq_push_tag, cq_q[0].tag);
         chk("cq_resp", cq_push_resp, cq_q[0].resp);
         chk("cq_len_err", cq_push_len_err, cq_q[0].len_err);
         if (d_cq_rdy) void'(cq_q.pop_front());
      end
      iss = d_issue_vld && !m_open[d_issue_tag];
      if (d_rvalid && exp_rdy) begin
         t     = d_rid[1:0];
         r_acc = 1'b1;
         if (m_open[t]) begin
            m_cnt[t]++;
            if (d_rresp > m_worst[t]) m_worst[t] = d_rresp;
            b.tag  = t;
            b.data = d_rdata;
            b.resp = d_rresp;
            b.last = d_rlast;
            rdf_q.push_back(b);
            if (d_rlast) begin
               c.tag     = t;
               c.resp    = m_worst[t];
               c.len_err = (m_cnt[t] != m_len[t] + 1);
               cq_q.push_back(c);
               m_open[t] = 1'b0;
            end
         end else begin
            stray_flag = 1'b1;
         end
      end
      if (iss) begin
         m_open[d_issue_tag]  = 1'b1;
         m_cnt[d_issue_tag]   = 0;
         m_worst[d_issue_tag] = '0;
         m_len[d_issue_tag]   = d_issue_len;
      end
   endtask

   task automatic idle(input int n);
      d_rvalid    = 1'b0;
      d_issue_vld = 1'b0;
      d_rdf_rdy   = 1'b1;
      d_cq_rdy    = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic issue(input logic [1:0] tag, input logic [7:0] len);
      d_issue_vld = 1'b1;
      d_issue_tag = tag;
      d_issue_len = len;
      step();
      d_issue_vld = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] tag, input logic [1:0] resp, input logic last);
      logic [1:0] hi;
      hi       = 2'($urandom_range(0, 3));
      d_rvalid = 1'b1;
      d_rid    = {hi, tag};
      d_rdata  = {$urandom, $urandom};
      d_rresp  = resp;
      d_rlast  = last;
      for (int k = 0; k < 20; k++) begin
         step();
         if (r_acc) break;
      end
      if (!r_acc) chk("beat_accept_timeout", 0, 1);
      d_rvalid = 1'b0;
   endtask

   initial begin
      int unsigned opens[$];
      int unsigned pick;
      n_chk  = 0;
      n_pass = 0;
      model_clear();

      d_preset = 1'b1;
      for (int i = 0; i < 3; i++) step();
      d_preset = 1'b0;
      idle(2);

      // four OKAY beats, exact length
      issue(2'd1, 8'd3);
      for (int i = 0; i < 4; i++) send_beat(2'd1, 2'b00, i == 3);
      idle(3);

      // worst response folds to SLVERR
      issue(2'd0, 8'd1);
      send_beat(2'd0, 2'b00, 1'b0);
      send_beat(2'd0, 2'b10, 1'b1);
      idle(3);

      // early rlast -> length error, tag closed
      issue(2'd2, 8'd3);
      send_beat(2'd2, 2'b01, 1'b0);
      send_beat(2'd2, 2'b00, 1'b1);
      d_issue_tag = 2'd2;
      idle(3);

      // beat to a closed tag
      send_beat(2'd3, 2'b11, 1'b0);
      idle(3);

      // RDF stalled on a last beat while CQ drains
      issue(2'd1, 8'd0);
      d_rdf_rdy = 1'b0;
      send_beat(2'd1, 2'b11, 1'b1);
      for (int i = 0; i < 5; i++) step();
      idle(3);

      // overrun: more beats than len, error reported at rlast
      issue(2'd3, 8'd0);
      for (int i = 0; i < 3; i++) send_beat(2'd3, 2'(i), i == 2);
      idle(3);

      // reissue refused in the rlast cycle, accepted the cycle after
      issue(2'd0, 8'd0);
      d_issue_vld = 1'b1;
      d_issue_tag = 2'd0;
      d_issue_len = 8'd2;
      send_beat(2'd0, 2'b00, 1'b1);
      step();
      d_issue_vld = 1'b0;
      for (int i = 0; i < 3; i++) send_beat(2'd0, 2'b01, i == 2);
      idle(3);

      // reset during beat 2 of 4
      issue(2'd2, 8'd3);
      send_beat(2'd2, 2'b00, 1'b0);
      d_rvalid = 1'b1;
      d_rid    = 4'd2;
      d_preset = 1'b1;
      step();
      step();
      d_preset = 1'b0;
      d_rvalid = 1'b0;
      for (int i = 0; i < TAG_NUM; i++) begin
         d_issue_tag = 2'(i);
         step();
      end
      idle(3);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         d_preset    = ($urandom_range(0, 499) == 0);
         d_issue_vld = ($urandom_range(0, 99) < 30);
         d_issue_tag = 2'($urandom_range(0, 3));
         d_issue_len = 8'($urandom_range(0, 4));
         d_rvalid    = ($urandom_range(0, 99) < 60);
         opens.delete();
         for (int i = 0; i < TAG_NUM; i++) if (m_open[i]) opens.push_back(i);
         d_rid = 4'($urandom_range(0, 15));
         if (opens.size() != 0 && $urandom_range(0, 99) < 85)
            d_rid[1:0] = 2'(opens[$urandom_range(0, opens.size() - 1)]);
         pick    = d_rid[1:0];
         d_rdata = {$urandom, $urandom};
         d_rresp = 2'($urandom_range(0, 3));
         if (m_open[pick] && m_cnt[pick] + 1 >= m_len[pick] + 1)
            d_rlast = ($urandom_range(0, 99) < 70);
         else
            d_rlast = ($urandom_range(0, 99) < 10);
         d_rdf_rdy = ($urandom_range(0, 99) < 70);
         d_cq_rdy  = ($urandom_range(0, 99) < 70);
         step();
      end
      d_preset = 1'b0;
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
